packet_consumer: RTL and testbench
==================================

# packet_consumer

Read-side client of the producer/consumer FIFO. Pops 16-bit words from the FIFO consumer port in the `rclk` domain and parses them into framed packets. Forwards payload words to a downstream valid/ready stream and checks each packet's checksum. Reports per-packet status pulses and running counters to the status block.

## Interface
- `MARKER`, default 8'hA5: value required in header bits [15:8].
- `CNT_W`, default 16: width of `pkt_cnt` and `drop_cnt`.

- `rclk`  in  1  read-domain clock; all logic on the rising edge.
- `rrst_n`  in  1  asynchronous, active-low reset.
- `rpop`  out  1  consume the FIFO head word at this edge.
- `rempty`  in  1  FIFO empty; `rdata` is valid only while low.
- `rdata`  in  16  FIFO head word, show-ahead (first-word fall-through).
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the beat when high with `out_valid`.
- `out_data`  out  16  payload word.
- `out_last`  out  1  marks the final payload beat of a packet.
- `pkt_ok`  out  1  one-cycle pulse: checksum matched.
- `pkt_err`  out  1  one-cycle pulse: checksum mismatched.
- `pkt_cnt`  out  CNT_W  packets completed (ok or err); wraps.
- `drop_cnt`  out  CNT_W  words discarded while hunting for a header; saturates at all-ones.

## Operation
- **Frame format:**
  - Header word: [15:8] = `MARKER`, [7:0] = payload length N (0..255).
  - Then N payload words.
  - Then one checksum word = (header + all payload words) mod 2^16.
- **FIFO protocol:**
  - The head word is visible on `rdata` whenever `rempty`=0.
  - `rpop`=1 at a rising edge consumes that word.
  - `rpop` is never asserted while `rempty`=1. It is combinational from `rempty`, the current state and the output-register status.
- **State HUNT** (reset state):
  - `rpop` = !`rempty`.
  - If the popped word has [15:8]==`MARKER`: latch N into the remaining counter, set sum = word.
    - N>0: go to PAYLOAD.
    - N==0: go to CHECK.
  - Otherwise: discard the word and increment `drop_cnt` (saturating). Stay in HUNT.
- **State PAYLOAD:**
  - `rpop` = !`rempty` && (!`out_valid` || `out_ready`).
  - Each popped word is loaded into the output register with `out_valid`=1, and is added to sum (16-bit wrap).
  - The remaining counter decrements on each pop.
  - When the popped word is the last one (remaining==1): `out_last`=1 for that beat, go to CHECK.
- **State CHECK:**
  - `rpop` = !`rempty`. The FIFO pop does not wait on downstream.
  - On pop, compare the word with sum:
    - Equal: pulse `pkt_ok`.
    - Not equal: pulse `pkt_err`.
  - Increment `pkt_cnt` in both cases, then return to HUNT.
- **Output register:**
  - A single entry.
  - `out_valid` clears on (`out_valid` && `out_ready`) when no new word loads in the same cycle.
  - `out_data` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.
- Payload is already forwarded before the checksum verdict. Downstream uses `pkt_err` to discard the packet.
- No data word is ever duplicated or dropped in PAYLOAD under any backpressure pattern.

## Timing
- **Reset values:** `rpop`=0 (FIFO is empty in reset), `out_valid`=0, `out_data`=0, `out_last`=0, `pkt_ok`=0, `pkt_err`=0, `pkt_cnt`=0, `drop_cnt`=0, state=HUNT, sum=0.
- **Latency:**
  - A payload word popped at edge k is presented on `out_data` with `out_valid`=1 after edge k.
  - The `pkt_ok`/`pkt_err` pulse is high for the one cycle after the checksum pop edge.
  - `pkt_cnt` updates at the same edge.
- **Throughput:** with `out_ready` held high and the FIFO never empty, one word is popped per cycle. A packet with N payload words takes N+2 cycles.
- **Simultaneous drain and load:** `out_ready`=1 with a new pop in the same cycle loads the new word. `out_valid` stays 1 with no bubble.
- **FIFO empty mid-packet:** the state holds and `out_valid` drains normally. There is no timeout.
- **Reset asserted mid-packet:** everything returns to reset values immediately (asynchronously). The rest of the partial packet is then hunted through and counted in `drop_cnt`.
- **Boundaries:**
  - N==0 is legal and produces no output beat.
  - N==255 is legal.
  - A `MARKER` byte appearing inside payload is not interpreted.

## Test plan
- **Good packet:** FIFO holds 0xA502, 0x0001, 0x0002, 0xA505, `out_ready`=1 → beats 0x0001, then 0x0002 with `out_last`; one `pkt_ok` pulse; `pkt_cnt`=1; `drop_cnt`=0; total 4 pops in 4 cycles.
- **Bad checksum:** same frame with checksum 0xA506 → same two beats; `pkt_err` pulses once; `pkt_ok` stays 0; `pkt_cnt`=1.
- **Backpressure:** 0xA503 plus 3 payload words, `out_ready` toggling 1,0,0,1,0,1 → `out_data` stable while stalled; all 3 words delivered in order, `out_last` on the third; no pop occurs while the output register is full and not draining.
- **Resync:** FIFO holds 0x1234, 0xFFFF, then 0xA500, 0xA500 → `drop_cnt`=2; zero output beats; `pkt_ok` once.
- **Empty gaps and reset:** drive `rempty`=1 between every word → `rpop` never asserted while empty; result identical to the good-packet case. Assert `rrst_n`=0 after the first payload beat → all outputs return to reset values; the remaining payload and checksum words count into `drop_cnt` unless they match `MARKER`.
- **Max length:** 0xA5FF, 255 words 0x0001..0x00FF, correct checksum → 255 beats, `out_last` only on 0x00FF, `pkt_ok`; 257 pops.

Source files
------------

// File: rtl/packet_consumer_if.sv
// FIFO read port plus downstream payload stream of the packet consumer.
// master = the consumer, slave = the FIFO/sink side.
interface packet_consumer_if;
   logic        rpop;
   logic        rempty;
   logic [15:0] rdata;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;

   modport master (output rpop, out_valid, out_data, out_last,
                   input  rempty, rdata, out_ready);
   modport slave  (input  rpop, out_valid, out_data, out_last,
                   output rempty, rdata, out_ready);
endinterface

// File: rtl/packet_consumer.sv
// Pops framed packets (header, N payload words, checksum) from a show-ahead FIFO,
// forwards payload through a one-entry output register and reports checksum verdicts.
module packet_consumer #(
   parameter logic [7:0] MARKER = 8'hA5,
   parameter int         CNT_W  = 16
) (
   input  logic                rclk_i,
   input  logic                rrst_n_i,
   packet_consumer_if.master   bus,
   output logic                pkt_ok_o,
   output logic                pkt_err_o,
   output logic [CNT_W-1:0]    pkt_cnt_o,
   output logic [CNT_W-1:0]    drop_cnt_o
);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_e;

   state_e             state_q, state_d;
   logic [7:0]         rem_q, rem_d;
   logic [15:0]        sum_q, sum_d;
   logic               out_valid_q, out_valid_d;
   logic [15:0]        out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic               pkt_ok_q, pkt_ok_d;
   logic               pkt_err_q, pkt_err_d;
   logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic               pop;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      sum_d       = sum_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      pkt_ok_d    = 1'b0;
      pkt_err_d   = 1'b0;
      pkt_cnt_d   = pkt_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      pop         = 1'b0;

      // Drain first; a load in PAYLOAD below overrides it so drain+load has no bubble.
      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

      case (state_q)
         HUNT: begin
            pop = !bus.rempty;
            if (pop) begin
               if (bus.rdata[15:8] == MARKER) begin
                  rem_d   = bus.rdata[7:0];
                  sum_d   = bus.rdata;
                  state_d = (bus.rdata[7:0] == 8'd0) ? CHECK : PAYLOAD;
               end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
                  drop_cnt_d = drop_cnt_q + CNT_W'(1);
               end
            end
         end
         PAYLOAD: begin
            pop = !bus.rempty && (!out_valid_q || bus.out_ready);
            if (pop) begin
               out_valid_d = 1'b1;
               out_data_d  = bus.rdata;
               out_last_d  = (rem_q == 8'd1);
               sum_d       = sum_q + bus.rdata;
               rem_d       = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = CHECK;
            end
         end
         CHECK: begin
            // Verdict pop never waits on the downstream stream.
            pop = !bus.rempty;
            if (pop) begin
               pkt_ok_d  = (bus.rdata == sum_q);
               pkt_err_d = (bus.rdata != sum_q);
               pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
               state_d   = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge rclk_i or negedge rrst_n_i) begin
      if (!rrst_n_i) begin
         state_q     <= HUNT;
         rem_q       <= '0;
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         pkt_ok_q    <= 1'b0;
         pkt_err_q   <= 1'b0;
         pkt_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         sum_q       <= sum_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         pkt_ok_q    <= pkt_ok_d;
         pkt_err_q   <= pkt_err_d;
         pkt_cnt_q   <= pkt_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign bus.rpop      = pop;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign pkt_ok_o      = pkt_ok_q;
   assign pkt_err_o     = pkt_err_q;
   assign pkt_cnt_o     = pkt_cnt_q;
   assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_packet_consumer.sv
// Drives a modelled show-ahead FIFO and a ready pattern into packet_consumer and
// compares beats, verdicts and counters against a frame-level parse of the word stream.
module tb_packet_consumer;
   localparam logic [7:0] MARKER = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pkt_ok, pkt_err;
   logic [15:0] pkt_cnt, drop_cnt;

   packet_consumer_if bus();

   packet_consumer #(.MARKER(MARKER), .CNT_W(16)) dut (
      .rclk_i     (clk),
      .rrst_n_i   (rst_n),
      .bus        (bus),
      .pkt_ok_o   (pkt_ok),
      .pkt_err_o  (pkt_err),
      .pkt_cnt_o  (pkt_cnt),
      .drop_cnt_o (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [15:0] fifo_q[$];
   logic [16:0] obs_beats[$], exp_beats[$];
   bit          obs_verd[$], exp_verd[$];
   int          exp_drops, exp_pkts;
   int          ready_mode, gap_mode;
   bit          ready_pat[$];
   bit          gap_tgl;
   int          cyc, pops, first_pop, last_pop;
   bit          popped_last, held;
   logic [16:0] held_beat;

   // Frame-level parse of whatever is still queued, starting from the hunt state.
   function automatic void model();
      int i, n;
      logic [15:0] w, sum;
      exp_beats.delete();
      exp_verd.delete();
      exp_drops = 0;
      exp_pkts  = 0;
      i = 0;
      while (i < fifo_q.size()) begin
         w = fifo_q[i];
         if (w[15:8] != MARKER) begin
            exp_drops++;
            i++;
         end else begin
            n   = int'(w[7:0]);
            sum = w;
            for (int j = 1; j <= n; j++)
               if (i + j < fifo_q.size()) begin
                  sum = sum + fifo_q[i+j];
                  exp_beats.push_back({(j == n), fifo_q[i+j]});
               end
            if (i + n + 1 < fifo_q.size()) begin
               exp_verd.push_back(fifo_q[i+n+1] == sum);
               exp_pkts++;
            end
            i = i + n + 2;
         end
      end
   endfunction

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.rempty    = 1'b1;
      bus.out_ready = 1'b0;
      bus.rdata     = 16'h0;
      #1;
      chk("rst_rpop",      32'(bus.rpop),      0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data",  32'(bus.out_data),  0);
      chk("rst_out_last",  32'(bus.out_last),  0);
      chk("rst_pkt_ok",    32'(pkt_ok),        0);
      chk("rst_pkt_err",   32'(pkt_err),       0);
      chk("rst_pkt_cnt",   32'(pkt_cnt),       0);
      chk("rst_drop_cnt",  32'(drop_cnt),      0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      held = 1'b0;
      popped_last = 1'b0;
      obs_beats.delete();
      obs_verd.delete();
      pops = 0;
      cyc = 0;
      first_pop = 0;
      last_pop = 0;
   endtask

   task automatic step();
      @(negedge clk);
      if (popped_last) void'(fifo_q.pop_front());
      if (pkt_ok || pkt_err) begin
         chk("pulse_both", 32'(pkt_ok && pkt_err), 0);
         obs_verd.push_back(pkt_ok);
      end
      chk("pkt_cnt_track", 32'(pkt_cnt), 32'(obs_verd.size()));
      if (held) begin
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk("stall_beat", 32'({bus.out_last, bus.out_data}), 32'(held_beat));
      end
      case (ready_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
         default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (fifo_q.size() == 0) bus.rempty = 1'b1;
      else begin
         case (gap_mode)
            0: bus.rempty = 1'b0;
            1: begin gap_tgl = !gap_tgl; bus.rempty = gap_tgl; end
            default: bus.rempty = ($urandom_range(0, 2) == 0);
         endcase
      end
      bus.rdata = bus.rempty ? 16'($urandom) : fifo_q[0];
      #1;
      chk("rpop_empty", 32'(bus.rpop && bus.rempty), 0);
      if (bus.out_valid && bus.out_ready) obs_beats.push_back({bus.out_last, bus.out_data});
      held = bus.out_valid && !bus.out_ready;
      held_beat = {bus.out_last, bus.out_data};
      popped_last = bus.rpop;
      if (bus.rpop) begin
         if (pops == 0) first_pop = cyc;
         last_pop = cyc;
         pops++;
      end
      cyc++;
   endtask

   task automatic run(input string name, input bit rst_mid);
      bit fired;
      int idle, nb, nv;
      fired = 1'b0;
      idle = 0;
      gap_tgl = 1'b0;
      model();
      do_reset();
      while (idle < 4 && cyc < 20000) begin
         step();
         if (rst_mid && !fired && obs_beats.size() > 0) begin
            fired = 1'b1;
            do_reset();
            model();
         end
         if (fifo_q.size() == 0 && !bus.out_valid && !popped_last) idle++;
         else idle = 0;
      end
      chk({name, "_done"}, 32'(idle >= 4), 1);
      chk({name, "_nbeats"}, 32'(obs_beats.size()), 32'(exp_beats.size()));
      nb = (obs_beats.size() < exp_beats.size()) ? obs_beats.size() : exp_beats.size();
      for (int i = 0; i < nb; i++)
         chk($sformatf("%s_beat%0d", name, i), 32'(obs_beats[i]), 32'(exp_beats[i]));
      chk({name, "_nverd"}, 32'(obs_verd.size()), 32'(exp_verd.size()));
      nv = (obs_verd.size() < exp_verd.size()) ? obs_verd.size() : exp_verd.size();
      for (int i = 0; i < nv; i++)
         chk($sformatf("%s_verd%0d", name, i), 32'(obs_verd[i]), 32'(exp_verd[i]));
      chk({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkts));
      chk({name, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
   endtask

   task automatic add_frame(input int n, input bit bad);
      logic [15:0] w, s;
      w = {MARKER, 8'(n)};
      fifo_q.push_back(w);
      s = w;
      for (int j = 0; j < n; j++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 7) == 0) w[15:8] = MARKER;
         fifo_q.push_back(w);
         s = s + w;
      end
      fifo_q.push_back(bad ? s + 16'd1 : s);
   endtask

   initial begin
      logic [15:0] w, s;
      ready_mode = 0;
      gap_mode = 0;

      fifo_q = '{16'hA502, 16'h0001, 16'h0002, 16'hA505};
      run("good", 1'b0);
      chk("good_pops", 32'(pops), 4);
      chk("good_span", 32'(last_pop - first_pop + 1), 4);

      fifo_q = '{16'hA502, 16'h0001, 16'h0002, 16'hA506};
      run("badsum", 1'b0);

      fifo_q = '{16'hA503, 16'h0001, 16'h0002, 16'h0003, 16'hA509};
      ready_mode = 1;
      ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      run("backpr", 1'b0);
      ready_mode = 0;

      fifo_q = '{16'h1234, 16'hFFFF, 16'hA500, 16'hA500};
      run("resync", 1'b0);

      fifo_q = '{16'hA502, 16'h0001, 16'h0002, 16'hA505};
      gap_mode = 1;
      run("gaps", 1'b0);
      gap_mode = 0;

      fifo_q = '{16'hA502, 16'h0001, 16'h0002, 16'hA505, 16'h0042, 16'hA501, 16'h0007, 16'hA508};
      run("rstmid", 1'b1);

      w = 16'hA5FF;
      fifo_q = '{w};
      s = w;
      for (int i = 1; i <= 255; i++) begin
         fifo_q.push_back(16'(i));
         s = s + 16'(i);
      end
      fifo_q.push_back(s);
      run("maxlen", 1'b0);
      chk("maxlen_pops", 32'(pops), 257);
      chk("maxlen_span", 32'(last_pop - first_pop + 1), 257);

      ready_mode = 2;
      gap_mode = 2;
      for (int r = 0; r < 8; r++) begin
         fifo_q.delete();
         for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 2) == 0) begin
               w = 16'($urandom);
               if (w[15:8] == MARKER) w[15:8] = 8'h00;
               fifo_q.push_back(w);
            end
            add_frame(($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 12)),
                      ($urandom_range(0, 3) == 0));
         end
         run($sformatf("rand%0d", r), (r == 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
